fifo_mac_seq: RTL and testbench
===============================

Name: fifo_mac_seq

Overview:
Sequencer for the two 8-deep input FIFOs (operand A, operand B) in front of the MAC unit. On start it clears the MAC and fills both FIFOs in lockstep from an upstream valid/ready source, one pair per beat. It then drains both FIFOs together into the MAC and pulses done when the accumulated result is final. It only generates control signals; data passes directly from upstream to FIFO to MAC.

Parameters:
DEPTH, 8, entries per FIFO and operand pairs per job; must be at least 2.
CNT_W, $clog2(DEPTH)+1, beat counter width; localparam, not overridable.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a job; sampled only in IDLE
in_valid  in  1  upstream has an A/B operand pair on its data lines
in_ready  out  1  controller accepts the pair this cycle
full_a  in  1  FIFO A full
full_b  in  1  FIFO B full
empty_a  in  1  FIFO A empty
empty_b  in  1  FIFO B empty
fifo_wren  out  1  write enable, wired to both FIFOs
fifo_rden  out  1  read enable, wired to both FIFOs
mac_clr  out  1  synchronous clear of the MAC accumulator
mac_en  out  1  MAC accumulate enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; MAC result is valid
err  out  1  sticky underflow flag; cleared by the next accepted start

Behaviour:
- Reset (async assert, sync release): state IDLE, cnt 0, rd_d 0, err 0. Every output is 0 while reset is asserted, including the combinational ones.
- FIFO contract: o_data is valid the cycle after rden, so mac_en = rd_d (fifo_rden registered once).
- States: IDLE, FILL, DRAIN, FLUSH, DONE.
- IDLE: in_ready=0. When start=1: mac_clr=1 that cycle, cnt<=0, err<=0, go to FILL.
- FILL:
  - in_ready = !full_a && !full_b.
  - fifo_wren = in_valid && in_ready (combinational, same cycle); cnt increments on each write.
  - Write with cnt==DEPTH-1: cnt<=0, go to DRAIN.
  - in_valid low means no write and no count; FILL has no timeout.
- DRAIN:
  - fifo_rden = !empty_a && !empty_b; cnt increments on each read.
  - Read with cnt==DEPTH-1: go to FLUSH.
  - Either FIFO empty with cnt<DEPTH: err<=1, go to IDLE with fifo_rden=0. The rd_d pipeline still completes its last mac_en.
- FLUSH: one cycle; mac_en is high from the final read. Go to DONE.
- DONE: done=1 for exactly one cycle, go to IDLE. First read to done is DEPTH+2 cycles.
- start outside IDLE is ignored. start held high re-triggers the cycle after DONE.
- fifo_wren and fifo_rden are never high in the same cycle.
- in_ready is 0 outside FILL.
- cnt never exceeds DEPTH-1.
- Reset mid-job: immediate return to IDLE. FIFO contents are not this block's responsibility; the FIFOs share rst_n.

Decomposition:
- Package fifo_mac_pkg: state enum seq_state_t {IDLE, FILL, DRAIN, FLUSH, DONE} and the constant DEFAULT_DEPTH = 8.
- Single module, no sub-module: one state register, one counter, one delay flop.

Test Plan:
- Reset with start=1 and in_valid=1 -> all outputs 0. After release, busy=0 and in_ready=0 until start.
- Start, then 8 back-to-back in_valid beats with a simple FIFO and MAC model, pairs A=1..8 and B=2 -> fifo_wren high 8 cycles, then fifo_rden high 8 cycles, mac_en lags by 1, done 10 cycles after the first rden, result 72.
- Same job with in_valid toggling 1,0,1,0 -> exactly 8 writes. in_ready stays 1, and fifo_wren is high only when in_valid is high.
- Force full_a=1 for 3 cycles during FILL -> in_ready=0 and no writes in those cycles; the job still completes with 8 pairs.
- Force empty_b=1 after 4 reads -> err=1, busy=0 next cycle, done never pulses. A new start clears err.
- Pulse start during DRAIN, then assert rst_n=0 mid-FILL of a second job -> the first pulse is ignored; the reset returns all outputs to 0 immediately.

Source files
------------

// File: rtl/fifo_mac_pkg.sv
// Shared types for the MAC operand FIFO sequencer: job state encoding and default job size.
package fifo_mac_pkg;

  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    FLUSH,
    DONE
  } seq_state_t;

endpackage

// File: rtl/fifo_mac_seq.sv
// Fills both operand FIFOs in lockstep, then drains them into the MAC; done is DEPTH+2 cycles after the first read counted inclusively.
// Upstream is stalled through in_ready when either FIFO is full; a FIFO running empty mid-drain aborts the job and sets err.
module fifo_mac_seq
  import fifo_mac_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic full_a,
  input  logic full_b,
  input  logic empty_a,
  input  logic empty_b,
  output logic fifo_wren,
  output logic fifo_rden,
  output logic mac_clr,
  output logic mac_en,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             rd_d;
  logic             err_q;

  // rst_n gates the start-driven clear so nothing leaks out while reset is held.
  assign in_ready  = rst_n && (state == FILL) && !full_a && !full_b;
  assign fifo_wren = in_ready && in_valid;
  assign fifo_rden = rst_n && (state == DRAIN) && !empty_a && !empty_b;
  assign mac_clr   = rst_n && (state == IDLE) && start;
  assign mac_en    = rd_d;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rd_d  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      // FIFO read data lands one cycle after rden, so the MAC enable trails it.
      rd_d <= fifo_rden;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            err_q <= 1'b0;
            state <= FILL;
          end
        end
        FILL: begin
          if (fifo_wren) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (fifo_rden) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= FLUSH;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            // Underflow: abandon the job; the in-flight mac_en still completes.
            cnt   <= '0;
            err_q <= 1'b1;
            state <= IDLE;
          end
        end
        FLUSH:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_mac_seq.sv
// Directed bench for fifo_mac_seq with behavioural operand FIFOs and a MAC model.
module tb_fifo_mac_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic start, in_valid, in_ready;
  logic full_a, full_b, empty_a, empty_b;
  logic fifo_wren, fifo_rden, mac_clr, mac_en, busy, done, err;

  logic [7:0]  a_dat, b_dat;
  logic [7:0]  mem_a [8];
  logic [7:0]  mem_b [8];
  logic [2:0]  wp, rp;
  int          occ;
  logic [7:0]  out_a, out_b;
  logic [31:0] acc;
  logic        force_full_a, force_empty_b, model_clr;
  logic [7:0]  out_vec;

  int n_vec = 0;
  int n_miscmp = 0;

  int nwr, nrd, first_rd, done_cyc, ndone, err_cyc;
  int viol_gate, viol_lag, viol_overlap, viol_full, viol_rdy;
  logic prev_rden, busy_post, busy_at_err, err_c1;
  logic [31:0] acc_at_done;

  always #5 clk = ~clk;

  fifo_mac_seq #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .full_a    (full_a),
    .full_b    (full_b),
    .empty_a   (empty_a),
    .empty_b   (empty_b),
    .fifo_wren (fifo_wren),
    .fifo_rden (fifo_rden),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  assign out_vec = {in_ready, fifo_wren, fifo_rden, mac_clr, mac_en, busy, done, err};
  assign full_a  = force_full_a || (occ == 8);
  assign full_b  = (occ == 8);
  assign empty_a = (occ == 0);
  assign empty_b = force_empty_b || (occ == 0);

  // Operand FIFOs (shared rst_n) and the MAC accumulator.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 3'd0; rp <= 3'd0; occ <= 0;
      out_a <= 8'd0; out_b <= 8'd0; acc <= 32'd0;
    end else begin
      if (model_clr) begin
        wp <= 3'd0; rp <= 3'd0; occ <= 0;
      end else begin
        if (fifo_wren) begin
          mem_a[wp] <= a_dat; mem_b[wp] <= b_dat; wp <= wp + 3'd1;
        end
        if (fifo_rden) begin
          out_a <= mem_a[rp]; out_b <= mem_b[rp]; rp <= rp + 3'd1;
        end
        occ <= occ + (fifo_wren ? 1 : 0) - (fifo_rden ? 1 : 0);
      end
      if (mac_clr) acc <= 32'd0;
      else if (mac_en) acc <= acc + 32'(out_a) * 32'(out_b);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One job: start, then feed A=1..8 / B=2 and watch the drain.
  task automatic run_job(input bit toggle, input int full_at, input int empty_after,
                         input int start_at_rd, input int max_cyc);
    int idx = 0;
    nwr = 0; nrd = 0; first_rd = -1; done_cyc = -1; ndone = 0; err_cyc = -1;
    viol_gate = 0; viol_lag = 0; viol_overlap = 0; viol_full = 0; viol_rdy = 0;
    prev_rden = 1'b0; busy_post = 1'b1; busy_at_err = 1'b1; err_c1 = 1'b1;
    acc_at_done = 32'hffff_ffff;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    #1;
    check_eq("clr_on_start", 32'(mac_clr), 32'd1);
    for (int c = 1; c < max_cyc; c++) begin
      @(negedge clk);
      start         = (start_at_rd >= 0) && (nrd == start_at_rd);
      in_valid      = toggle ? ((c % 2) == 1) : 1'b1;
      a_dat         = 8'(idx + 1);
      b_dat         = 8'd2;
      force_full_a  = (full_at >= 0) && (c >= full_at) && (c < full_at + 3);
      force_empty_b = (empty_after >= 0) && (nrd >= empty_after);
      #1;
      if (c == 1) err_c1 = err;
      if (mac_en !== prev_rden) viol_lag++;
      if (fifo_wren && fifo_rden) viol_overlap++;
      if (fifo_wren && !in_valid) viol_gate++;
      if (force_full_a && (in_ready || fifo_wren)) viol_full++;
      if (nwr < 8 && !force_full_a && !in_ready) viol_rdy++;
      if (nwr == 8 && in_ready) viol_rdy++;
      if (fifo_wren) begin nwr++; idx++; end
      if (fifo_rden) begin
        if (first_rd < 0) first_rd = c;
        nrd++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = c; acc_at_done = acc; end
      end
      prev_rden = fifo_rden;
      if (done_cyc >= 0 && c == done_cyc + 1) begin busy_post = busy; break; end
      if (err && err_cyc < 0) begin err_cyc = c; busy_at_err = busy; end
      if (err_cyc >= 0 && c >= err_cyc + 3) break;
    end
    start = 1'b0; in_valid = 1'b0; force_full_a = 1'b0; force_empty_b = 1'b0;
  endtask

  task automatic check_good_job(input string nm);
    check_eq({nm, "_writes"}, 32'(nwr), 32'd8);
    check_eq({nm, "_reads"}, 32'(nrd), 32'd8);
    // First rden cycle counts as cycle 1, so done lands DEPTH+1 cycles later.
    check_eq({nm, "_done_lat"}, 32'(done_cyc - first_rd), 32'd9);
    check_eq({nm, "_done_pulses"}, 32'(ndone), 32'd1);
    check_eq({nm, "_result"}, acc_at_done, 32'd72);
    check_eq({nm, "_mac_en_lag"}, 32'(viol_lag), 32'd0);
    check_eq({nm, "_wr_rd_overlap"}, 32'(viol_overlap), 32'd0);
    check_eq({nm, "_wren_gate"}, 32'(viol_gate), 32'd0);
    check_eq({nm, "_in_ready"}, 32'(viol_rdy), 32'd0);
    check_eq({nm, "_busy_after_done"}, 32'(busy_post), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1;
    force_full_a = 1'b0; force_empty_b = 1'b0; model_clr = 1'b0;
    a_dat = 8'd0; b_dat = 8'd0;
    #3;
    check_eq("reset_outs", 32'(out_vec), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("reset_outs_held", 32'(out_vec), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_in_ready", 32'(in_ready), 32'd0);
    end

    run_job(1'b0, -1, -1, -1, 60);
    check_good_job("b2b");

    run_job(1'b1, -1, -1, -1, 80);
    check_good_job("toggle");

    run_job(1'b0, 3, -1, -1, 60);
    check_good_job("full_a");
    check_eq("full_a_blocked", 32'(viol_full), 32'd0);

    run_job(1'b0, -1, 4, -1, 60);
    check_eq("uf_reads", 32'(nrd), 32'd4);
    check_eq("uf_err_seen", 32'(err_cyc > 0), 32'd1);
    check_eq("uf_busy_with_err", 32'(busy_at_err), 32'd0);
    check_eq("uf_no_done", 32'(ndone), 32'd0);
    check_eq("uf_mac_en_lag", 32'(viol_lag), 32'd0);

    @(negedge clk); model_clr = 1'b1;
    @(negedge clk); model_clr = 1'b0;
    check_eq("err_sticky", 32'(err), 32'd1);

    // Fresh start clears err; a start pulse mid-drain must be ignored.
    run_job(1'b0, -1, -1, 3, 60);
    check_eq("err_cleared", 32'(err_c1), 32'd0);
    check_good_job("start_in_drain");

    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk); start = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk); #1;
    check_eq("mid_fill_busy", 32'(busy), 32'd1);
    check_eq("mid_fill_occ", 32'(occ), 32'd3);
    start = 1'b1; rst_n = 1'b0;
    #1;
    check_eq("mid_job_reset_outs", 32'(out_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    check_eq("post_reset_busy", 32'(busy), 32'd0);
    check_eq("post_reset_in_ready", 32'(in_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
